// File: rtl/uzneel_pkg.sv
// Shared types for the uzneel/gvgsqe frame interface: frame shape, element
// geometry, packer state encoding and the element-index-to-position decode.
package uzneel_pkg;

   localparam int ELEM_W = 3;
   localparam int N_ELEM = 18;
   localparam int CNT_W  = 5;

   typedef logic [2:3][0:2][2:4][ELEM_W-1:0] uzneel_t;
   typedef logic [1:1][2:2]                  gvgsqe_t;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   // Index widths match the declared ranges of uzneel_t: [2:3], [0:2], [2:4].
   typedef struct packed {
      logic [1:0] i;
      logic [1:0] j;
      logic [2:0] m;
   } elem_pos_t;

   // Element k lands at uzneel[2+k/9][(k/3)%3][2+k%3]; only k in 0..17 is meaningful.
   function automatic elem_pos_t elem_pos(input logic [CNT_W-1:0] k);
      elem_pos_t p;
      p.i = 2'd2 + 2'(k / 5'd9);
      p.j = 2'((k / 5'd3) % 5'd3);
      p.m = 3'd2 + 3'(k % 5'd3);
      return p;
   endfunction

endpackage

// File: rtl/uzneel_frame_packer.sv
// Packs 3-bit elements into the 54-bit uzneel frame plus its OR-reduction; frame valid the cycle after the last accept.
// Accepts only in FILL (in_ready from state alone); holds the frame in FULL until out_ready, abort overrides both.
module uzneel_frame_packer
   import uzneel_pkg::*;
#(
   parameter bit LAST_EN = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [ELEM_W-1:0]   in_data,
   input  logic                in_last,
   output logic                in_ready,
   input  logic                abort,
   output logic                out_valid,
   input  logic                out_ready,
   output uzneel_t             uzneel,
   output gvgsqe_t             gvgsqe,
   output logic                out_short,
   output logic [CNT_W-1:0]    out_count
);

   localparam logic [CNT_W-1:0] K_LAST = CNT_W'(N_ELEM - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] k_q, k_d;
   uzneel_t          frame_q, frame_d;
   gvgsqe_t          gv_q, gv_d;
   logic             short_q, short_d;
   logic [CNT_W-1:0] count_q, count_d;
   elem_pos_t        pos;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      frame_d = frame_q;
      short_d = short_q;
      count_d = count_q;
      pos     = elem_pos(k_q);

      if (abort) begin
         state_d = FILL;
         k_d     = '0;
         frame_d = '0;
         short_d = 1'b0;
         count_d = '0;
      end else begin
         case (state_q)
            FILL: begin
               if (in_valid) begin
                  frame_d[pos.i][pos.j][pos.m] = in_data;
                  k_d     = k_q + 1'b1;
                  count_d = k_q + 1'b1;
                  // in_last on the final element is redundant, so short stays 0 there.
                  if (k_q == K_LAST || (LAST_EN && in_last)) begin
                     state_d = FULL;
                     short_d = (k_q < K_LAST);
                  end
               end
            end
            FULL: begin
               if (out_ready) begin
                  state_d = FILL;
                  k_d     = '0;
                  frame_d = '0;
                  short_d = 1'b0;
                  count_d = '0;
               end
            end
            default: begin
               state_d = FILL;
            end
         endcase
      end

      gv_d = |frame_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         k_q     <= '0;
         frame_q <= '0;
         gv_q    <= '0;
         short_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         frame_q <= frame_d;
         gv_q    <= gv_d;
         short_q <= short_d;
         count_q <= count_d;
      end
   end

   assign in_ready  = (state_q == FILL);
   assign out_valid = (state_q == FULL);
   assign uzneel    = frame_q;
   assign gvgsqe    = gv_q;
   assign out_short = short_q;
   assign out_count = count_q;

endmodule

// File: tb/tb_uzneel_frame_packer.sv
// Directed bench for uzneel_frame_packer: expected frames are queued as elements are driven
// and popped when the packer presents a frame.
`define CHK(tag, obs, exp) chk(tag, 64'(obs), 64'(exp))

module tb_uzneel_frame_packer;
   import uzneel_pkg::*;

   typedef struct packed {
      logic [53:0] f;
      logic        g;
      logic        sh;
      logic [4:0]  cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0, in_last = 1'b0, abort = 1'b0, out_ready = 1'b0;
   logic [2:0] in_data = 3'd0;
   logic       in_ready, out_valid, out_short;
   logic [4:0] out_count;
   uzneel_t    uzneel;
   gvgsqe_t    gvgsqe;

   logic       b_in_valid = 1'b0, b_in_last = 1'b0, b_abort = 1'b0, b_out_ready = 1'b0;
   logic [2:0] b_in_data = 3'd0;
   logic       b_in_ready, b_out_valid, b_out_short;
   logic [4:0] b_out_count;
   uzneel_t    b_uzneel;
   gvgsqe_t    b_gvgsqe;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   uzneel_frame_packer #(.LAST_EN(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
      .uzneel(uzneel), .gvgsqe(gvgsqe), .out_short(out_short), .out_count(out_count)
   );

   uzneel_frame_packer #(.LAST_EN(1'b0)) u_dut_nolast (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_data(b_in_data), .in_last(b_in_last), .in_ready(b_in_ready),
      .abort(b_abort), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .uzneel(b_uzneel), .gvgsqe(b_gvgsqe), .out_short(b_out_short), .out_count(b_out_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Element k occupies flat bits [3*(17-k) +: 3] of the packed frame.
   function automatic logic [53:0] put(input logic [53:0] f, input int k, input logic [2:0] d);
      logic [53:0] r;
      r = f;
      r[3*(17-k) +: 3] = d;
      return r;
   endfunction

   task automatic send_elem(input logic [2:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic expect_frame(input string tag);
      exp_t e;
      int   n;
      n = 0;
      while (out_valid !== 1'b1 && n < 25) begin
         step();
         n++;
      end
      `CHK($sformatf("%s.valid", tag), out_valid, 1'b1);
      e = sb.pop_front();
      `CHK($sformatf("%s.frame", tag), uzneel, e.f);
      `CHK($sformatf("%s.gvgsqe", tag), gvgsqe, e.g);
      `CHK($sformatf("%s.short", tag), out_short, e.sh);
      `CHK($sformatf("%s.count", tag), out_count, e.cnt);
   endtask

   task automatic handoff(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      `CHK($sformatf("%s.ho_in_ready", tag), in_ready, 1'b1);
      `CHK($sformatf("%s.ho_out_valid", tag), out_valid, 1'b0);
      `CHK($sformatf("%s.ho_frame", tag), uzneel, 54'd0);
      `CHK($sformatf("%s.ho_count", tag), out_count, 5'd0);
      `CHK($sformatf("%s.ho_short", tag), out_short, 1'b0);
   endtask

   initial begin
      exp_t        e;
      logic [53:0] f;

      // Reset state
      #12 rst_n = 1'b1;
      step();
      `CHK("rst.in_ready", in_ready, 1'b1);
      `CHK("rst.out_valid", out_valid, 1'b0);
      `CHK("rst.frame", uzneel, 54'd0);
      `CHK("rst.gvgsqe", gvgsqe, 1'b0);
      `CHK("rst.short", out_short, 1'b0);
      `CHK("rst.count", out_count, 5'd0);

      // Full frame of 3'b101 back-to-back with out_ready held high
      out_ready = 1'b1;
      f = '0;
      for (int k = 0; k < 18; k++) begin
         send_elem(3'b101, 1'b0);
         f = put(f, k, 3'b101);
         vectors++;
         if (out_valid !== (k == 17)) begin
            miscompares++;
            $error("FAIL t1.valid_after_%0d: observed %b", k, out_valid);
         end
      end
      e = '{f: f, g: 1'b1, sh: 1'b0, cnt: 5'd18};
      sb.push_back(e);
      expect_frame("t1");
      `CHK("t1.in_ready_full", in_ready, 1'b0);
      handoff("t1");

      // Short frame closed by in_last on element 4
      f = '0;
      for (int k = 0; k < 5; k++) begin
         send_elem(3'(k + 1), (k == 4));
         f = put(f, k, 3'(k + 1));
      end
      e = '{f: f, g: 1'b1, sh: 1'b1, cnt: 5'd5};
      sb.push_back(e);
      expect_frame("t2");
      `CHK("t2.elem_2_1_3", uzneel[2][1][3], 3'd5);
      handoff("t2");

      // All-zero frame held under backpressure; in_valid pulses are dropped
      for (int k = 0; k < 18; k++) send_elem(3'b000, 1'b0);
      e = '{f: 54'd0, g: 1'b0, sh: 1'b0, cnt: 5'd18};
      sb.push_back(e);
      expect_frame("t3");
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 2 == 0);
         in_data  = 3'd7;
         step();
         vectors++;
         if (out_valid !== 1'b1) begin
            miscompares++;
            $error("FAIL t3.hold_valid_%0d", i);
         end
         vectors++;
         if (in_ready !== 1'b0) begin
            miscompares++;
            $error("FAIL t3.hold_in_ready_%0d", i);
         end
         vectors++;
         if (uzneel !== 54'd0) begin
            miscompares++;
            $error("FAIL t3.hold_frame_%0d", i);
         end
         vectors++;
         if (out_count !== 5'd18) begin
            miscompares++;
            $error("FAIL t3.hold_count_%0d", i);
         end
      end
      in_valid = 1'b0;
      handoff("t3");

      // Abort after 7 elements, with a competing accept in the abort cycle
      for (int k = 0; k < 7; k++) send_elem(3'b111, 1'b0);
      abort    = 1'b1;
      in_valid = 1'b1;
      in_data  = 3'b111;
      step();
      abort    = 1'b0;
      in_valid = 1'b0;
      `CHK("t4.abort_in_ready", in_ready, 1'b1);
      `CHK("t4.abort_frame", uzneel, 54'd0);
      `CHK("t4.abort_gvgsqe", gvgsqe, 1'b0);
      `CHK("t4.abort_count", out_count, 5'd0);
      f = '0;
      for (int k = 0; k < 18; k++) begin
         send_elem(3'b010, (k == 17));
         f = put(f, k, 3'b010);
      end
      e = '{f: f, g: 1'b1, sh: 1'b0, cnt: 5'd18};
      sb.push_back(e);
      expect_frame("t4");
      handoff("t4");

      // abort together with out_ready in FULL
      f = '0;
      for (int k = 0; k < 18; k++) begin
         send_elem(3'(k % 8), 1'b0);
         f = put(f, k, 3'(k % 8));
      end
      e = '{f: f, g: 1'b1, sh: 1'b0, cnt: 5'd18};
      sb.push_back(e);
      expect_frame("t5");
      abort     = 1'b1;
      out_ready = 1'b1;
      step();
      abort     = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (in_ready !== 1'b1) begin
            miscompares++;
            $error("FAIL t5.in_ready_%0d", i);
         end
         vectors++;
         if (out_valid !== 1'b0) begin
            miscompares++;
            $error("FAIL t5.out_valid_%0d", i);
         end
         vectors++;
         if (uzneel !== 54'd0) begin
            miscompares++;
            $error("FAIL t5.frame_%0d", i);
         end
         vectors++;
         if (out_count !== 5'd0) begin
            miscompares++;
            $error("FAIL t5.count_%0d", i);
         end
         step();
      end

      // Asynchronous reset between edges in the middle of a frame
      for (int k = 0; k < 6; k++) send_elem(3'b110, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      `CHK("t6.in_ready", in_ready, 1'b1);
      `CHK("t6.out_valid", out_valid, 1'b0);
      `CHK("t6.frame", uzneel, 54'd0);
      `CHK("t6.gvgsqe", gvgsqe, 1'b0);
      `CHK("t6.short", out_short, 1'b0);
      `CHK("t6.count", out_count, 5'd0);
      #2 rst_n = 1'b1;
      step();
      `CHK("t6.post_count", out_count, 5'd0);
      `CHK("t6.post_frame", uzneel, 54'd0);

      // LAST_EN=0: in_last on element 2 does not close the frame
      f = '0;
      for (int k = 0; k < 18; k++) begin
         b_in_valid = 1'b1;
         b_in_data  = 3'(k + 1);
         b_in_last  = (k == 2);
         step();
         b_in_valid = 1'b0;
         b_in_last  = 1'b0;
         f = put(f, k, 3'(k + 1));
         if (k < 17) begin
            `CHK($sformatf("t7.valid_after_%0d", k), b_out_valid, 1'b0);
         end
      end
      `CHK("t7.valid", b_out_valid, 1'b1);
      `CHK("t7.frame", b_uzneel, f);
      `CHK("t7.count", b_out_count, 5'd18);
      `CHK("t7.short", b_out_short, 1'b0);
      `CHK("t7.gvgsqe", b_gvgsqe, 1'b1);
      b_out_ready = 1'b1;
      step();
      b_out_ready = 1'b0;
      `CHK("t7.ho_in_ready", b_in_ready, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uzneel_frame_packer.md
# uzneel_frame_packer

Assembles the 54-bit `uzneel` frame, typed `[2:3][0:2][2:4][2:0]`, from a narrow 3-bit element stream and presents it to the gate-level frame consumer. It is the writer side of the `uzneel`/`gvgsqe` interface. The consumer reduces the frame, so the packer also supplies the frame's OR-reduction as the companion `gvgsqe` bit. It sits between the stimulus/element source and the consumer, with valid/ready handshakes on both sides.

## Interface
Parameters:
- `LAST_EN`, default 1: honour `in_last` for early frame termination. When 0, `in_last` is ignored.

Ports:
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `in_valid` input, 1 bit: element present.
- `in_data` input, 3 bits `[2:0]`: element value.
- `in_last` input, 1 bit: this element closes the frame early.
- `in_ready` output, 1 bit: packer accepts an element this cycle.
- `abort` input, 1 bit: synchronous discard of the current frame.
- `out_valid` output, 1 bit: frame complete and stable.
- `out_ready` input, 1 bit: consumer takes the frame.
- `uzneel` output, typed `[2:3][0:2][2:4][2:0]` (54 bits): assembled frame.
- `gvgsqe` output, typed `[1:1][2:2]` (1 bit): OR of all 54 frame bits.
- `out_short` output, 1 bit: frame was closed by `in_last` before element 17.
- `out_count` output, 5 bits: number of elements written, 1..18.

## Operation
- Two states:
  - FILL: `in_ready`=1.
  - FULL: `in_ready`=0, `out_valid`=1.
- Element index k runs 0..17 and maps to `uzneel[2+k/9][(k/3)%3][2+k%3]`. The leftmost dimension is slowest.
- FILL, on accept (`in_valid && in_ready`):
  - Write `in_data` at index k, then k←k+1.
  - If k==17, or (`LAST_EN` && `in_last`), go to FULL.
  - Latch `out_short` = (k<17) and `out_count` = k+1.
- Elements not written in a short frame read as 3'b000. The frame register is cleared on every entry to FILL.
- FULL:
  - `uzneel`, `gvgsqe`, `out_short` and `out_count` are held stable.
  - On `out_ready`: clear the frame, k←0, `out_short`←0, `out_count`←0, go to FILL.
- `abort` has the highest priority and is valid in any state:
  - Next state is FILL, with k, frame, `out_short` and `out_count` cleared.
  - An accept or handoff in the same cycle is discarded.
- `gvgsqe` = |`uzneel`, registered together with the frame. It equals the OR of all accepted elements.
- `in_valid` while `in_ready`=0 is ignored; the source must hold the element.
- `in_last` on element 17 is redundant: the frame is full, and `out_short`=0.

## Timing
- Reset values:
  - state = FILL, k = 0
  - `in_ready` = 1, `out_valid` = 0
  - `uzneel` = 0, `gvgsqe` = 0
  - `out_short` = 0, `out_count` = 0
- `in_ready` is decoded from the state register only, with no combinational path from `out_ready`.
- Latency: the final element accepted at edge N gives `out_valid`=1 after edge N, i.e. visible in cycle N+1.
- Handoff:
  - `out_valid && out_ready` at edge M gives `in_ready`=1 in cycle M+1.
  - There is no same-cycle refill, so the minimum period is 19 cycles per full frame.
- `out_valid` never drops without `out_ready` or `abort`.
- Reset asserted mid-frame: immediate return to the reset values; the partial frame is lost.
- Reset deassertion takes effect on the first rising edge after `rst_n` rises.

## Structure
- Shared package `uzneel_pkg` holds:
  - `ELEM_W`=3, `N_ELEM`=18
  - typedef `uzneel_t` (`[2:3][0:2][2:4][2:0]`), typedef `gvgsqe_t` (`[1:1][2:2]`)
  - state enum `{FILL, FULL}`
  - function `elem_pos(k)` returning the (i, j, m) triple
- No sub-module. The index-to-position decode is the package function; the rest is one state register, a 5-bit counter and the frame register.

## Test plan
- Reset, then 18 elements 3'b101 back-to-back with `out_ready`=1:
  - `out_valid` is high exactly in cycle 19.
  - All elements read 3'b101, `gvgsqe`=1, `out_count`=18, `out_short`=0.
  - `in_ready` returns in cycle 20.
- Elements k=0..4 with values 1,2,3,4,5, `in_last` on the 5th:
  - `uzneel[2][1][3]`=5, all later elements 0.
  - `out_short`=1, `out_count`=5.
- All-zero full frame, with `out_ready` held low for 10 cycles:
  - `gvgsqe`=0 and `out_valid` stays high with the frame stable.
  - `in_ready`=0 throughout; `in_valid` pulses are dropped.
- `abort` after 7 elements, then 18 fresh elements of 3'b010:
  - The output frame contains only 3'b010, `out_count`=18.
- `abort` and `out_ready` in the same FULL cycle:
  - FILL next cycle with the frame cleared and no double handoff.
- `rst_n` pulsed low asynchronously between edges mid-frame:
  - All outputs are at reset values before the next edge.
- `LAST_EN`=0 with `in_last` on element 3:
  - The frame continues to 18 elements.
